// File: rtl/pc_fetch_gen.sv
// Fetch-stage PC generator: owns PCF, picks the next fetch address and holds EX redirects
// across fetch stalls. Define PC_FETCH_STATS_EN to build the branch/mispredict counters.
module pc_fetch_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 PC_SEL,
  input  logic [31:0]          PC_PRE,
  input  logic                 btb_prefail,
  input  logic                 btb_fill,
  input  logic [31:0]          PCE,
  input  logic [31:0]          BranchTarget,
  input  logic                 JalrE,
  input  logic [31:0]          JalrTarget,
  input  logic                 JalD,
  input  logic [31:0]          JalTarget,
  input  logic [2:0]           BranchTypeE,
  output logic [31:0]          PCF,
  output logic                 redirect_pend,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  logic        ex_redir;
  logic [31:0] ex_pc;
  logic [31:0] next_pc;
  logic        pend_vld;
  logic [31:0] pend_pc;

  assign ex_redir = btb_prefail | btb_fill | JalrE;

  // btb_prefail wins if it ever coincides with btb_fill
  always_comb begin
    ex_pc = JalrTarget;
    if (btb_prefail) begin
      ex_pc = PCE + 32'd4;
    end else if (btb_fill) begin
      ex_pc = BranchTarget;
    end
  end

  always_comb begin
    next_pc = PCF + 32'd4;
    if (ex_redir) begin
      next_pc = ex_pc;
    end else if (pend_vld) begin
      next_pc = pend_pc;
    end else if (JalD) begin
      next_pc = JalTarget;
    end else if (PC_SEL) begin
      next_pc = PC_PRE;
    end
  end

  // Only EX redirects are held; D and IF sources re-present themselves after the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF      <= RESET_PC;
      pend_vld <= 1'b0;
      pend_pc  <= 32'h0;
    end else if (!StallF) begin
      PCF      <= next_pc;
      pend_vld <= 1'b0;
    end else if (ex_redir) begin
      pend_pc  <= ex_pc;
      pend_vld <= 1'b1;
    end
  end

  assign redirect_pend = pend_vld;

`ifdef PC_FETCH_STATS_EN
  logic br_ev;
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] mispred_cnt_q;

  assign br_ev = !StallE && !FlushE && (BranchTypeE != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (br_ev) begin
      if (br_cnt_q != '1) begin
        br_cnt_q <= br_cnt_q + 1'b1;
      end
      if ((btb_prefail | btb_fill) && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{StallE, FlushE, BranchTypeE};
  assign br_cnt       = '0;
  assign mispred_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed steps from the plan, then random traffic
// compared against a behavioural model of the fetch redirect rules and statistics counters.
module tb_pc_fetch_gen;

  localparam logic [31:0] RPC = 32'h100;
  localparam int unsigned CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          StallF, StallE, FlushE, PC_SEL, btb_prefail, btb_fill, JalrE, JalD;
  logic [31:0]   PC_PRE, PCE, BranchTarget, JalrTarget, JalTarget;
  logic [2:0]    BranchTypeE;
  logic [31:0]   PCF;
  logic          redirect_pend;
  logic [CW-1:0] br_cnt, mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pc;
  logic        m_hold;
  logic [31:0] m_hold_pc;
  int          m_br, m_mis;

  pc_fetch_gen #(.RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallE(StallE), .FlushE(FlushE),
    .PC_SEL(PC_SEL), .PC_PRE(PC_PRE), .btb_prefail(btb_prefail), .btb_fill(btb_fill),
    .PCE(PCE), .BranchTarget(BranchTarget), .JalrE(JalrE), .JalrTarget(JalrTarget),
    .JalD(JalD), .JalTarget(JalTarget), .BranchTypeE(BranchTypeE), .PCF(PCF),
    .redirect_pend(redirect_pend), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] eb, em;
`ifdef PC_FETCH_STATS_EN
    eb = 32'(m_br);
    em = 32'(m_mis);
`else
    eb = 32'h0;
    em = 32'h0;
`endif
    check({tag, ".pcf"}, PCF, m_pc);
    check({tag, ".pend"}, {31'h0, redirect_pend}, {31'h0, m_hold});
    check({tag, ".br"}, {{(32-CW){1'b0}}, br_cnt}, eb);
    check({tag, ".mis"}, {{(32-CW){1'b0}}, mispred_cnt}, em);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_hold = 1'b0; m_hold_pc = 32'h0; m_br = 0; m_mis = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    logic [31:0] ex_tgt;
    logic        ex_ev;
    logic [31:0] cand [5];
    logic        vld  [5];
    ex_ev  = btb_prefail || btb_fill || JalrE;
    ex_tgt = btb_prefail ? PCE + 32'd4 : (btb_fill ? BranchTarget : JalrTarget);
    cand[0] = ex_tgt;       vld[0] = ex_ev;
    cand[1] = m_hold_pc;    vld[1] = m_hold;
    cand[2] = JalTarget;    vld[2] = JalD;
    cand[3] = PC_PRE;       vld[3] = PC_SEL;
    cand[4] = m_pc + 32'd4; vld[4] = 1'b1;
    if (!StallF) begin
      for (int i = 4; i >= 0; i--) if (vld[i]) m_pc = cand[i];
      m_hold = 1'b0;
    end else if (ex_ev) begin
      m_hold = 1'b1;
      m_hold_pc = ex_tgt;
    end
    if (!StallE && !FlushE && BranchTypeE != 3'd0) begin
      if (m_br < CMAX) m_br++;
      if ((btb_prefail || btb_fill) && m_mis < CMAX) m_mis++;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    StallF = 0; StallE = 0; FlushE = 0; PC_SEL = 0; btb_prefail = 0; btb_fill = 0;
    JalrE = 0; JalD = 0; BranchTypeE = 3'd0;
    PC_PRE = 32'h0; PCE = 32'h0; BranchTarget = 32'h0; JalrTarget = 32'h0; JalTarget = 32'h0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("first_fetch");
    for (int i = 0; i < 3; i++) tick("seq");
    check("seq_10c", PCF, 32'h10C);

    JalD = 1; JalTarget = 32'h200; tick("jal_200");
    idle(); PC_SEL = 1; PC_PRE = 32'h400; tick("btb_400");
    check("btb_400_lit", PCF, 32'h400);
    idle(); JalD = 1; JalTarget = 32'h200; tick("jal_200b");
    PC_SEL = 1; PC_PRE = 32'h400; JalD = 1; JalTarget = 32'h800; tick("jal_over_btb");
    check("jal_over_btb_lit", PCF, 32'h800);

    idle(); btb_prefail = 1; PCE = 32'h40; PC_SEL = 1; PC_PRE = 32'h300;
    JalD = 1; JalTarget = 32'h700; tick("prefail");
    check("prefail_lit", PCF, 32'h44);
    idle(); btb_fill = 1; BranchTarget = 32'h90; tick("fill");
    check("fill_lit", PCF, 32'h90);

    idle(); StallF = 1; JalrE = 1; JalrTarget = 32'h500; tick("stall1");
    check("stall1_pend", {31'h0, redirect_pend}, 32'h1);
    idle(); StallF = 1; btb_fill = 1; BranchTarget = 32'h600; tick("stall2");
    idle(); StallF = 1; PC_SEL = 1; PC_PRE = 32'hA00; tick("stall3");
    idle(); JalD = 1; JalTarget = 32'hB00; tick("unstall");
    check("unstall_lit", PCF, 32'h600);

    idle(); JalD = 1; JalTarget = 32'hFFFF_FFFC; tick("to_top");
    idle(); tick("wrap");
    check("wrap_lit", PCF, 32'h0);
    StallF = 1; JalrE = 1; JalrTarget = 32'hC00; tick("pend_before_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_rst");

    // Statistics: 5 counted branches (2 mispredicted) and one flushed branch
    for (int i = 0; i < 6; i++) begin
      idle();
      StallF = 1;
      BranchTypeE = 3'(1 + i % 6);
      btb_fill = (i == 1 || i == 3 || i == 5);
      BranchTarget = 32'h1000 + 32'(i * 16);
      FlushE = (i == 5);
      tick("stats");
    end
`ifdef PC_FETCH_STATS_EN
    check("br_five", {{(32-CW){1'b0}}, br_cnt}, 32'd5);
    check("mis_two", {{(32-CW){1'b0}}, mispred_cnt}, 32'd2);
`endif
    for (int i = 0; i < 20; i++) begin
      idle();
      BranchTypeE = 3'd2; btb_prefail = 1; PCE = 32'h2000;
      tick("sat");
    end
`ifdef PC_FETCH_STATS_EN
    check("br_sat", {{(32-CW){1'b0}}, br_cnt}, 32'(CMAX));
    check("mis_sat", {{(32-CW){1'b0}}, mispred_cnt}, 32'(CMAX));
`endif

    // Random traffic; reset once to let counters move again
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int sel;
      StallF = ($urandom_range(0, 9) < 3);
      StallE = ($urandom_range(0, 9) < 2);
      FlushE = ($urandom_range(0, 9) < 2);
      PC_SEL = $urandom_range(0, 1);
      JalD   = ($urandom_range(0, 9) < 2);
      sel    = $urandom_range(0, 9);
      btb_prefail = (sel == 0);
      btb_fill    = (sel == 1);
      JalrE       = (sel == 2) || ($urandom_range(0, 19) == 0);
      BranchTypeE = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      PC_PRE       = $urandom;
      PCE          = $urandom;
      BranchTarget = $urandom;
      JalrTarget   = $urandom;
      JalTarget    = $urandom;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
